mdu_sequencer: RTL
==================

Name: mdu_sequencer

Overview:
- Iterative 32-bit multiply/divide unit that time-shares the existing 32-bit ALU as its adder/subtractor.
- Does not instantiate the ALU. It drives external alu_a/alu_b/alu_ctr ports and reads back alu_res; the ALU is combinational, so the result is available in the same cycle.
- Carry/borrow are derived locally with an unsigned comparator, because the ALU exposes only a 32-bit result.
- Produces MIPS-style HI/LO results for mult, multu, div, divu; sits beside the integer pipeline, which stalls on busy.

Parameters:
- WIDTH, 32, operand width (only 32 verified).
- ALU_ADD, 4'b0001, ALU control code for unsigned add (no overflow trap).
- ALU_SUB, 4'b0011, ALU control code for unsigned subtract (no overflow trap).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; latched with start.
- a  in  WIDTH  multiplicand/dividend; latched with start.
- b  in  WIDTH  multiplier/divisor; latched with start.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- done  out  1  one-cycle pulse when hi/lo are valid.
- hi  out  WIDTH  product[63:32] or remainder.
- lo  out  WIDTH  product[31:0] or quotient.
- div_zero  out  1  set when a div/divu completed with b==0; cleared on next accepted start.
- alu_a  out  WIDTH  ALU operand A.
- alu_b  out  WIDTH  ALU operand B.
- alu_ctr  out  4  ALU control.
- alu_res  in  WIDTH  ALU result (combinational from alu_a/alu_b/alu_ctr).

Behaviour:
- Reset: state=IDLE; busy, done, div_zero = 0; hi, lo = 0; internal regs = 0. Reset mid-operation aborts to IDLE and produces no done.
- FSM: IDLE -> RUN (32 cycles, 6-bit counter) -> FIXUP (1) -> DONE (1) -> IDLE.
- Latency: start sampled at edge 0 → RUN cycles 1..32, FIXUP 33, done=1 in cycle 34. busy=1 in cycles 1..34.
- start while busy is ignored. DONE returns to IDLE; a new start can be accepted in the cycle after done.
- IDLE accept:
  - Latch op and operand signs.
  - Signed ops (mult, div) use magnitudes: |x| = ~x+1 computed locally; 0x80000000 stays 0x80000000.
  - Load P_hi=0, P_lo=|a| (or a), M=|b| (or b).
- Multiply RUN step:
  - alu_ctr=ALU_ADD, alu_a=P_hi, alu_b = P_lo[0] ? M : 0.
  - c = (alu_res < alu_a) unsigned.
  - P_hi <= {c, alu_res[31:1]}; P_lo <= {alu_res[0], P_lo[31:1]}.
- Divide RUN step (restoring):
  - r = {P_hi[30:0], P_lo[31]}, msb = P_hi[31].
  - alu_ctr=ALU_SUB, alu_a=r, alu_b=M.
  - ok = msb | (alu_res <= r).
  - P_hi <= ok ? alu_res : r; P_lo <= {P_lo[30:0], ok}.
- IDLE, FIXUP and DONE drive alu_ctr=ALU_ADD, alu_a=0, alu_b=0.
- FIXUP (local logic, not the ALU):
  - mult: 64-bit negate of {P_hi,P_lo} if signs of a and b differ.
  - div: negate quotient if signs differ; remainder takes sign of dividend (negate if a<0).
  - div/divu with b==0: lo=32'hFFFFFFFF, hi=original a, sign fixups bypassed, div_zero set.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
- hi, lo update only on entry to DONE and hold until the next completion or reset.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001; done exactly in cycle 34; busy high cycles 1..34.
- mult a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; alu_ctr=0001 during all RUN cycles.
- divu a=100 b=7 -> lo=14 hi=2; then divu a=0xFFFFFFFF b=1 -> lo=0xFFFFFFFF hi=0 (exercises msb path).
- div a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- divu a=0x80000000 b=0 -> lo=0xFFFFFFFF hi=0x80000000 div_zero=1; the next multu start clears div_zero.
- start multu, pulse start again at cycle 5 (ignored), assert rst at cycle 10 -> cycle 11: busy=0 hi=lo=0, no done pulse; a new start is accepted in cycle 12.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative 32-bit multiply/divide sequencer producing MIPS-style HI/LO.
// Borrows an external combinational ALU for its add/subtract each step.
module mdu_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [3:0] ALU_ADD = 4'b0001,
  parameter logic [3:0] ALU_SUB = 4'b0011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] alu_res
);

  // state | meaning
  // IDLE  | waiting for start; operands latched on accept
  // RUN   | 32 shift/add or shift/subtract steps through the ALU
  // FIXUP | sign correction and divide-by-zero substitution
  // DONE  | hi/lo valid, done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

  localparam logic [WIDTH-1:0]   ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2 = {{(2*WIDTH-1){1'b0}}, 1'b1};

  state_t           state, state_nx;
  logic [5:0]       cnt;
  logic [1:0]       op_q;
  logic             neg_a, neg_b, b_zero;
  logic [WIDTH-1:0] a_q, p_hi, p_lo, m;
  logic [WIDTH-1:0] p_hi_nx, p_lo_nx, fix_hi, fix_lo, div_r;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             sgn_op, a_neg_in, b_neg_in;
  logic [2*WIDTH-1:0] prod, prod_neg;

  assign sgn_op   = ~op[0];
  assign a_neg_in = sgn_op & a[WIDTH-1];
  assign b_neg_in = sgn_op & b[WIDTH-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign abs_a    = a_neg_in ? (~a + ONE) : a;
  assign abs_b    = b_neg_in ? (~b + ONE) : b;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  assign div_r    = {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
  assign prod     = {p_hi, p_lo};
  assign prod_neg = ~prod + ONE2;

  always_comb begin
    state_nx = state;
    alu_ctr  = ALU_ADD;
    alu_a    = '0;
    alu_b    = '0;
    p_hi_nx  = p_hi;
    p_lo_nx  = p_lo;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN: begin
        if (cnt == 6'd0) state_nx = S_FIXUP;
        if (!op_q[1]) begin
          alu_ctr = ALU_ADD;
          alu_a   = p_hi;
          alu_b   = p_lo[0] ? m : '0;
          // carry out of the 32-bit add becomes the new top bit
          p_hi_nx = {(alu_res < p_hi), alu_res[WIDTH-1:1]};
          p_lo_nx = {alu_res[0], p_lo[WIDTH-1:1]};
        end else begin
          alu_ctr = ALU_SUB;
          alu_a   = div_r;
          alu_b   = m;
          // a set msb means the shifted remainder exceeds any 32-bit divisor
          if (p_hi[WIDTH-1] || (alu_res <= div_r)) begin
            p_hi_nx = alu_res;
            p_lo_nx = {p_lo[WIDTH-2:0], 1'b1};
          end else begin
            p_hi_nx = div_r;
            p_lo_nx = {p_lo[WIDTH-2:0], 1'b0};
          end
        end
      end
      S_FIXUP: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    fix_hi = p_hi;
    fix_lo = p_lo;
    if (!op_q[1]) begin
      if (neg_a ^ neg_b) {fix_hi, fix_lo} = prod_neg;
    end else if (b_zero) begin
      fix_hi = a_q;
      fix_lo = '1;
    end else begin
      if (neg_a ^ neg_b) fix_lo = ~p_lo + ONE;
      if (neg_a)         fix_hi = ~p_hi + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      b_zero   <= 1'b0;
      a_q      <= '0;
      p_hi     <= '0;
      p_lo     <= '0;
      m        <= '0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start) begin
          op_q     <= op;
          neg_a    <= a_neg_in;
          neg_b    <= b_neg_in;
          b_zero   <= (b == '0);
          a_q      <= a;
          p_hi     <= '0;
          p_lo     <= abs_a;
          m        <= abs_b;
          cnt      <= 6'd31;
          div_zero <= 1'b0;
        end
        S_RUN: begin
          p_hi <= p_hi_nx;
          p_lo <= p_lo_nx;
          cnt  <= cnt - 6'd1;
        end
        S_FIXUP: begin
          hi       <= fix_hi;
          lo       <= fix_lo;
          div_zero <= op_q[1] & b_zero;
        end
        default: ;
      endcase
    end
  end

endmodule
